// File: rtl/line_buffer_3row.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer_3row
//  Purpose  : Delays a raster RGB pixel stream by one and two lines so that a
//             3x3 window stage receives three vertically aligned row streams.
//  Revision : 1.0 - initial release
// ============================================================================
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272,
    parameter int CW         = 9,
    parameter int RW         = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             rows_ready,
    output logic             eol,
    output logic             eof
);

    localparam logic [CW-1:0] c_LAST_COL = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] c_LAST_ROW = RW'(PIC_HEIGHT - 1);

    logic [WIDTH-1:0] r_mem_a [PIC_WIDTH];
    logic [WIDTH-1:0] r_mem_b [PIC_WIDTH];

    logic [CW-1:0]    r_col_cnt;
    logic [RW-1:0]    r_row_cnt;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [CW-1:0]    w_col_nxt;
    logic [RW-1:0]    w_row_nxt;
    logic             w_last_col;
    logic             w_last_row;
    logic [WIDTH-1:0] w_ra;
    logic [WIDTH-1:0] w_rb;

    logic             r_valid_out;
    logic [WIDTH-1:0] r_dout1;
    logic [WIDTH-1:0] r_dout2;
    logic [WIDTH-1:0] r_dout3;
    logic             r_rows_ready;
    logic             r_eol;
    logic             r_eof;

    // A beat arriving with sof is forced to position (row 0, col 0).
    assign w_col      = sof ? '0 : r_col_cnt;
    assign w_row      = sof ? '0 : r_row_cnt;
    assign w_last_col = (w_col == c_LAST_COL);
    assign w_last_row = (w_row == c_LAST_ROW);
    assign w_ra       = r_mem_a[w_col];
    assign w_rb       = r_mem_b[w_col];

    always_comb begin
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_row ? '0 : w_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (valid_in) begin
            r_col_cnt <= w_col_nxt;
            r_row_cnt <= w_row_nxt;
        end else if (sof) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end
    end

    // Asynchronous read above plus synchronous write gives read-before-write.
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            r_mem_a[w_col] <= din;
            r_mem_b[w_col] <= w_ra;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out  <= 1'b0;
            r_dout1      <= '0;
            r_dout2      <= '0;
            r_dout3      <= '0;
            r_rows_ready <= 1'b0;
            r_eol        <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            r_valid_out <= valid_in;
            r_eol       <= valid_in && w_last_col;
            r_eof       <= valid_in && w_last_col && w_last_row;
            if (valid_in) begin
                // Row gating hides stale memory contents from earlier frames.
                r_dout3      <= din;
                r_dout2      <= (w_row != '0) ? w_ra : '0;
                r_dout1      <= (w_row >= RW'(2)) ? w_rb : '0;
                r_rows_ready <= (w_row >= RW'(2));
            end
        end
    end

    assign valid_out  = r_valid_out;
    assign dout1      = r_dout1;
    assign dout2      = r_dout2;
    assign dout3      = r_dout3;
    assign rows_ready = r_rows_ready;
    assign eol        = r_eol;
    assign eof        = r_eof;

endmodule
`default_nettype wire
